line_mem_arbiter: RTL
=====================

Name: line_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Sits between the two caches (behind cpu ports a and b) and main memory.
- Registers the winning request, drives one memory transaction at a time, and returns a one-cycle response to the granted cache.
- Uses a last-grant round-robin on ties, so neither fetch nor data traffic starves.

Parameters:
ADDR_WIDTH, 32, byte address width on all sides
LINE_WIDTH, 256, cache line width in bits

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
i_read  in  1  icache line-read request; held until i_resp
i_address  in  ADDR_WIDTH  icache line address, stable while i_read
i_rdata  out  LINE_WIDTH  line returned to icache, valid with i_resp
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line-read request; held until d_resp
d_write  in  1  dcache line-writeback request; held until d_resp
d_address  in  ADDR_WIDTH  dcache line address, stable while request high
d_wdata  in  LINE_WIDTH  writeback line, stable while d_write
d_rdata  out  LINE_WIDTH  line returned to dcache, valid with d_resp
d_resp  out  1  one-cycle completion pulse to dcache
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_address  out  ADDR_WIDTH  memory line address
pmem_wdata  out  LINE_WIDTH  memory write data
pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion, one cycle

Behaviour:
- States: IDLE, MEM_I, MEM_D, RESP. Reset state is IDLE.
- Reset value of every output is 0. last_grant resets to D, so the first tie goes to I.
- IDLE, no request: stay in IDLE.
- IDLE, only i_read: latch i_address into addr_q, owner=I, go to MEM_I.
- IDLE, only d_read or d_write: latch d_address and d_wdata, latch op=write if d_write else read, owner=D, go to MEM_D.
- IDLE, both sides requesting: grant the side not equal to last_grant. Update last_grant at grant time.
- d_read and d_write together is illegal. It is treated as a write, and the read is not performed.
- MEM_I: pmem_read=1, pmem_address=addr_q. Both are registered, so they first appear the cycle after the request is sampled.
- MEM_D: pmem_read=!op, pmem_write=op, pmem_address=addr_q, pmem_wdata=wdata_q. All are held constant until pmem_resp.
- On pmem_resp in MEM_I or MEM_D:
  - capture pmem_rdata into rbuf (write: rbuf is don't-care and is not updated);
  - drop pmem_read/pmem_write the next cycle;
  - go to RESP.
- RESP: assert exactly one of i_resp/d_resp, per owner, for one cycle. i_rdata/d_rdata = rbuf. Go to IDLE.
- Requests are not sampled in RESP. Requesters deassert in the cycle after their resp, and IDLE re-samples then.
- i_rdata/d_rdata hold rbuf at all times; only the resp pulse qualifies them.
- Latency: request seen in IDLE at cycle 0 → pmem command from cycle 1. If pmem_resp arrives at cycle N, the cache resp is at cycle N+1, and a new grant is possible at cycle N+2.
- pmem_resp outside MEM_I/MEM_D is ignored.
- Requester inputs changing mid-transaction have no effect; address and data are latched at grant.
- Asynchronous reset mid-transaction:
  - all outputs go to 0 immediately and the state returns to IDLE;
  - the outstanding memory transaction is abandoned, and memory must be reset alongside;
  - no resp is issued for the aborted request.
- pmem_read and pmem_write are never high together. i_resp and d_resp are never high together.

Test Plan:
- Single icache miss: i_read=1, i_address=0x0000_0060 at cycle 0, memory resp at cycle 5 with rdata=0xA5..A5 → pmem_read cycles 1–5, pmem_address=0x60, i_resp=1 only at cycle 6 with i_rdata=0xA5..A5, d_resp stays 0.
- Dcache writeback: d_write=1, d_address=0x8000_0040, d_wdata=0x1234..; memory resp after 3 cycles → pmem_write=1 with matching address/data throughout, pmem_read=0, a single d_resp pulse.
- Tie after reset: i_read and d_read both asserted at cycle 0 → I served first. D (held) is granted the cycle after I's resp drops, and its d_resp follows; a second tie is then won by I again (last_grant=D).
- Back-to-back fairness: hold d_read continuously and re-raise i_read after each i_resp → grants alternate I, D, I, D, with no side granted twice in a row while the other waits.
- Reset mid-op: deassert reset_n during MEM_D with pmem_write=1 → pmem_write, pmem_read, and both resp outputs 0 in the same cycle, state IDLE. After release, a fresh i_read completes normally.
- Stray memory response: pulse pmem_resp in IDLE → no resp outputs asserted, state unchanged.

Source files
------------

// File: rtl/line_mem_arbiter_if.sv
// Cache-side and memory-side line bus of the line memory arbiter.
// master is the arbiter's view; slave is the caches/memory view.
interface line_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;
  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_address;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// Shares one physical-memory line port between icache and dcache,
// one transaction at a time, round-robin on simultaneous requests.
module line_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  line_mem_arbiter_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MEM_I = 2'd1;
  localparam logic [1:0] MEM_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]            state;
  logic                  owner_d, op_wr, last_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q, rbuf;
  logic                  rd_q, wr_q, i_resp_q, d_resp_q;
  logic                  d_req, grant_i, grant_d;

  // A simultaneous read+write from the dcache is handled as a write.
  assign d_req   = bus.d_read | bus.d_write;
  assign grant_i = bus.i_read & (~d_req | last_d);
  assign grant_d = d_req & ~grant_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      owner_d  <= 1'b0;
      op_wr    <= 1'b0;
      last_d   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf     <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            addr_q  <= bus.i_address;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            op_wr   <= 1'b0;
            rd_q    <= 1'b1;
            state   <= MEM_I;
          end else if (grant_d) begin
            addr_q  <= bus.d_address;
            wdata_q <= bus.d_wdata;
            owner_d <= 1'b1;
            last_d  <= 1'b1;
            op_wr   <= bus.d_write;
            rd_q    <= ~bus.d_write;
            wr_q    <= bus.d_write;
            state   <= MEM_D;
          end
        end
        MEM_I, MEM_D: begin
          if (bus.pmem_resp) begin
            if (!op_wr) rbuf <= bus.pmem_rdata;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            i_resp_q <= ~owner_d;
            d_resp_q <= owner_d;
            state    <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.i_resp       = i_resp_q;
  assign bus.d_resp       = d_resp_q;
  assign bus.i_rdata      = rbuf;
  assign bus.d_rdata      = rbuf;
endmodule
